keypad_debounce: RTL and testbench
==================================

Name: keypad_debounce

Overview:
- Front-end conditioning stage for the 10-key numeric keypad; sits directly upstream of the clock/alarm block and drives its `keypad` input.
- Synchronises raw key lines, debounces press and release, and rejects multi-key chords.
- Presents a clean one-hot level that goes non-zero exactly once per accepted press. Downstream edge detection (`keypad != 0` while previous was 0) therefore sees one event per press.
- Also provides the BCD code, a one-cycle strobe, an error strobe and optional auto-repeat.

Parameters:
- DEBOUNCE_CYC, 20: consecutive stable samples required to accept a press (20 ms at 1 kHz); legal range 2..255.
- RELEASE_CYC, 20: consecutive all-zero samples required to accept a release or leave lockout; legal range 2..255.
- REPEAT_EN, 0: 1 enables auto-repeat while a key is held.
- HOLD_CYC, 500: held cycles in PRESS before the first repeat.
- REPEAT_CYC, 200: cycles between subsequent repeats.

Ports:
- clk  in  1  system clock (1 kHz).
- rst  in  1  synchronous active-high reset.
- key_raw  in  10  raw key lines, active-high, bit n = digit n, asynchronous and bouncing.
- keypad  out  10  clean one-hot level, bit n = digit n held; 0 when none.
- key_code  out  4  BCD digit of the last accepted key (0..9).
- key_pulse  out  1  one-cycle strobe on each accepted press or repeat.
- key_err  out  1  one-cycle strobe when a chord is detected.

Behaviour:
- Interface: one clock `clk`; `rst` is synchronous and active-high. All state updates on posedge `clk`.
- Reset: keypad=0, key_code=0, key_pulse=0, key_err=0, both sync stages=0, all counters=0, state=IDLE. Reset mid-press drops keypad to 0 on the same edge, with no pulse. After rst deasserts, a key already held is treated as a fresh press.
- Synchroniser: 2-flop on all 10 bits gives key_s. key_raw captured at edge k is visible as key_s after edge k+1.
- "onehot" means exactly one bit of key_s is set. "cand" is the latched candidate vector. cnt is an 8-bit sample counter.
- IDLE (keypad=0):
  - key_s==0: stay.
  - onehot: cand<=key_s, cnt<=1, go to CAND.
  - more than one bit set: go to LOCK, key_err=1 for one cycle.
- CAND (keypad=0):
  - key_s==cand: cnt++. When cnt reaches DEBOUNCE_CYC, go to PRESS. On that edge: keypad<=cand, key_code<=BCD(cand), key_pulse=1 for one cycle.
  - key_s==0: go to IDLE (bounce rejected, no outputs).
  - other onehot: cand<=key_s, cnt<=1 (restart).
  - multi-bit: go to LOCK, key_err pulse.
- Press latency: raw press stable from edge 0 makes keypad and key_pulse visible after edge DEBOUNCE_CYC+1 (21 with defaults).
- PRESS (keypad=cand):
  - key_s==cand: hold. With REPEAT_EN=1, hcnt counts; at HOLD_CYC, then every REPEAT_CYC:
    - keypad<=0 for exactly one cycle, then cand again;
    - key_pulse=1 on the re-assert edge.
  - key_s==0: go to REL, cnt<=1, keypad unchanged.
  - any other non-zero value: go to LOCK, keypad<=0, key_err pulse.
- REL (keypad=cand):
  - key_s==0: cnt++. At RELEASE_CYC, go to IDLE and keypad<=0.
  - key_s==cand: return to PRESS (release bounce). No new pulse; hcnt is not reset.
  - anything else: go to LOCK, keypad<=0, key_err pulse.
- Release latency: raw release at edge 0 clears keypad after edge RELEASE_CYC+1.
- LOCK (keypad=0): cnt counts consecutive key_s==0 samples and resets to 0 on any non-zero sample. At RELEASE_CYC, go to IDLE. Further chords do not re-pulse key_err.
- Invariants:
  - keypad is always 0 or onehot.
  - key_pulse and key_err are never both 1.
  - key_code holds its value until the next accepted press.
- Counter saturation: cnt and hcnt saturate and never wrap. hcnt width is $clog2(max(HOLD_CYC, REPEAT_CYC)+1).

Decomposition:
- Shared package:
  - state enum {IDLE, CAND, PRESS, REL, LOCK}, 3-bit encoding;
  - functions is_onehot10 and onehot10_to_bcd, shared with the clock block's keypad decoder;
  - constant KEY_NONE = 10'b0.
- One sub-module: sync_2ff (parameterised width, reset to 0), reusable for the dip switch.

Test Plan:
- Clean press: key_raw=10'b0000001000 from edge 0, held 100 cycles, then released.
  - key_pulse high only after edge 21 with key_code=3.
  - keypad=10'b0000001000 from edge 21 until edge 21 after release.
- Bounce rejection: digit 7 toggled every 5 cycles for 60 cycles, then 0.
  - keypad stays 0 and key_pulse never fires.
- Release bounce: hold digit 5 for 40 cycles, drop 8 cycles, re-press for 30, release.
  - Exactly one key_pulse; keypad is continuously 10'b0000100000 until 21 cycles after the final release.
- Chord: hold digit 1; at cycle 30 add digit 2.
  - key_err pulses once; keypad goes 0 on the same edge.
  - Releasing only digit 2 gives no new press; releasing all lines for 20 samples returns to IDLE.
  - A following digit-9 press yields key_code=9.
- Auto-repeat (REPEAT_EN=1, HOLD_CYC=50, REPEAT_CYC=20): hold digit 0 for 130 cycles.
  - key_pulse count = 5 (initial + repeats at 50, 70, 90, 110 held cycles).
  - Each repeat has a single-cycle keypad=0 gap.
- Reset mid-press: assert rst for 1 cycle while in PRESS with digit 4 held.
  - All outputs 0 on that edge.
  - A new key_pulse arrives DEBOUNCE_CYC+2 edges after rst deasserts.

Source files
------------

// File: rtl/keypad_debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module   : keypad_debounce_pkg
// Purpose  : Shared types, constants and one-hot helpers for the 10-key
//            numeric keypad front end and the clock block's keypad decoder.
// Revision : 1.0 - initial release
// ============================================================================
package keypad_debounce_pkg;

  // Conditioning FSM states, fixed 3-bit encoding
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CAND  = 3'd1,
    PRESS = 3'd2,
    REL   = 3'd3,
    LOCK  = 3'd4
  } kd_state_t;

  localparam logic [9:0] KEY_NONE = 10'b0;

  // True when exactly one of the ten key lines is set
  function automatic logic is_onehot10(input logic [9:0] v);
    return (v != KEY_NONE) && ((v & (v - 10'd1)) == KEY_NONE);
  endfunction

  // Index of the set bit as a BCD digit; meaningful only for one-hot input
  function automatic logic [3:0] onehot10_to_bcd(input logic [9:0] v);
    logic [3:0] code;
    code = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (v[i]) code = 4'(i);
    end
    return code;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Purpose  : Two-flop synchroniser for a bus of independent asynchronous
//            level inputs (keypad lines, dip switches). Resets to zero.
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // First stage may go metastable; second stage gives it a full cycle to settle
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/keypad_debounce.sv
`default_nettype none
// ============================================================================
// Module   : keypad_debounce
// Purpose  : Synchronise, debounce and chord-filter the raw 10-key keypad.
//            Produces a clean one-hot level, BCD code, press strobe, chord
//            error strobe and optional auto-repeat.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_debounce
  import keypad_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 20,
  parameter int RELEASE_CYC  = 20,
  parameter int REPEAT_EN    = 0,
  parameter int HOLD_CYC     = 500,
  parameter int REPEAT_CYC   = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] key_raw,
  output logic [9:0] keypad,
  output logic [3:0] key_code,
  output logic       key_pulse,
  output logic       key_err
);

  localparam int HMAX = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int HW   = $clog2(HMAX + 1);

  localparam logic [7:0]    DEB_LIM  = 8'(DEBOUNCE_CYC);
  localparam logic [7:0]    REL_LIM  = 8'(RELEASE_CYC);
  localparam logic [HW-1:0] HOLD_LIM = HW'(HOLD_CYC);
  localparam logic [HW-1:0] REP_LIM  = HW'(REPEAT_CYC);
  localparam logic [HW-1:0] HCNT_ONE = HW'(1);

  logic [9:0]    key_s;
  kd_state_t     state, state_next;
  logic [9:0]    cand, cand_next;
  logic [7:0]    cnt, cnt_next, cnt_inc;
  logic [HW-1:0] hcnt, hcnt_next, hcnt_inc, hold_lim;
  logic          rep_phase, rep_phase_next;
  logic          gap, gap_next;
  logic [9:0]    keypad_next;
  logic [3:0]    key_code_next;
  logic          key_pulse_next, key_err_next;
  logic          onehot;

  sync_2ff #(.WIDTH(10)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (key_raw),
    .q   (key_s)
  );

  // Saturating increments so long holds never wrap back into a threshold
  assign cnt_inc  = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  assign hcnt_inc = (hcnt == '1) ? hcnt : hcnt + HCNT_ONE;
  // First repeat waits HOLD_CYC, later ones REPEAT_CYC
  assign hold_lim = rep_phase ? REP_LIM : HOLD_LIM;
  assign onehot   = is_onehot10(key_s);

  // State and output registers; outputs are registered so they are glitch-free
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cand      <= KEY_NONE;
      cnt       <= 8'd0;
      hcnt      <= '0;
      rep_phase <= 1'b0;
      gap       <= 1'b0;
      keypad    <= KEY_NONE;
      key_code  <= 4'd0;
      key_pulse <= 1'b0;
      key_err   <= 1'b0;
    end else begin
      state     <= state_next;
      cand      <= cand_next;
      cnt       <= cnt_next;
      hcnt      <= hcnt_next;
      rep_phase <= rep_phase_next;
      gap       <= gap_next;
      keypad    <= keypad_next;
      key_code  <= key_code_next;
      key_pulse <= key_pulse_next;
      key_err   <= key_err_next;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_next     = state;
    cand_next      = cand;
    cnt_next       = cnt;
    hcnt_next      = hcnt;
    rep_phase_next = rep_phase;
    gap_next       = 1'b0;
    keypad_next    = keypad;
    key_code_next  = key_code;
    key_pulse_next = 1'b0;
    key_err_next   = 1'b0;

    case (state)
      IDLE: begin
        if (onehot) begin
          cand_next  = key_s;
          cnt_next   = 8'd1;
          state_next = CAND;
        end else if (key_s != KEY_NONE) begin
          cnt_next     = 8'd0;
          state_next   = LOCK;
          key_err_next = 1'b1;
        end
      end

      CAND: begin
        if (key_s == cand) begin
          cnt_next = cnt_inc;
          if (cnt_inc >= DEB_LIM) begin
            state_next     = PRESS;
            keypad_next    = cand;
            key_code_next  = onehot10_to_bcd(cand);
            key_pulse_next = 1'b1;
            hcnt_next      = HCNT_ONE;
            rep_phase_next = 1'b0;
            cnt_next       = 8'd0;
          end
        end else if (key_s == KEY_NONE) begin
          cnt_next   = 8'd0;
          state_next = IDLE;
        end else if (onehot) begin
          cand_next = key_s;
          cnt_next  = 8'd1;
        end else begin
          cnt_next     = 8'd0;
          state_next   = LOCK;
          key_err_next = 1'b1;
        end
      end

      PRESS: begin
        if (key_s == cand) begin
          hcnt_next = hcnt_inc;
          if (gap) begin
            // Second half of a repeat: level returns and the strobe fires
            keypad_next    = cand;
            key_pulse_next = 1'b1;
          end else if ((REPEAT_EN != 0) && (hcnt_inc == hold_lim)) begin
            keypad_next    = KEY_NONE;
            gap_next       = 1'b1;
            hcnt_next      = '0;
            rep_phase_next = 1'b1;
          end
        end else if (key_s == KEY_NONE) begin
          // Restoring the level here covers a release landing on a repeat gap
          keypad_next = cand;
          cnt_next    = 8'd1;
          state_next  = REL;
        end else begin
          keypad_next  = KEY_NONE;
          cnt_next     = 8'd0;
          state_next   = LOCK;
          key_err_next = 1'b1;
        end
      end

      REL: begin
        if (key_s == KEY_NONE) begin
          cnt_next = cnt_inc;
          if (cnt_inc >= REL_LIM) begin
            keypad_next = KEY_NONE;
            cnt_next    = 8'd0;
            state_next  = IDLE;
          end
        end else if (key_s == cand) begin
          cnt_next   = 8'd0;
          state_next = PRESS;
        end else begin
          keypad_next  = KEY_NONE;
          cnt_next     = 8'd0;
          state_next   = LOCK;
          key_err_next = 1'b1;
        end
      end

      LOCK: begin
        // Only an unbroken run of all-zero samples leaves lockout
        if (key_s == KEY_NONE) begin
          cnt_next = cnt_inc;
          if (cnt_inc >= REL_LIM) begin
            cnt_next   = 8'd0;
            state_next = IDLE;
          end
        end else begin
          cnt_next = 8'd0;
        end
      end

      default: begin
        keypad_next = KEY_NONE;
        cnt_next    = 8'd0;
        state_next  = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_debounce
// Purpose  : Self-checking bench for keypad_debounce: directed vector table,
//            reset and auto-repeat sequences, and randomized stimulus
//            against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_debounce;

  localparam int DEB  = 20;
  localparam int RELC = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] key_raw = '0;

  logic [9:0] keypad_a, keypad_b;
  logic [3:0] code_a, code_b;
  logic       pulse_a, pulse_b, err_a, err_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  keypad_debounce #(
    .DEBOUNCE_CYC(DEB), .RELEASE_CYC(RELC), .REPEAT_EN(0),
    .HOLD_CYC(500), .REPEAT_CYC(200)
  ) dut_a (
    .clk(clk), .rst(rst), .key_raw(key_raw),
    .keypad(keypad_a), .key_code(code_a), .key_pulse(pulse_a), .key_err(err_a)
  );

  keypad_debounce #(
    .DEBOUNCE_CYC(DEB), .RELEASE_CYC(RELC), .REPEAT_EN(1),
    .HOLD_CYC(50), .REPEAT_CYC(20)
  ) dut_b (
    .clk(clk), .rst(rst), .key_raw(key_raw),
    .keypad(keypad_b), .key_code(code_b), .key_pulse(pulse_b), .key_err(err_b)
  );

  // ---------------------------------------------------------------- helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // ----------------------------------------------------------- vector table
  typedef struct {
    logic [9:0] raw;       // key lines held for the whole row
    int         cycles;    // clock edges in the row
    logic [9:0] kp;        // keypad at end of row
    int         code;      // key_code at end of row
    int         pulses;    // key_pulse count in row
    int         errs;      // key_err count in row
    int         change;    // first edge index where keypad differs from row start, -1 none
    int         pulse_at;  // edge index of first key_pulse, -1 none
  } row_t;

  row_t rows[$];

  task automatic add_row(input logic [9:0] raw, input int cycles, input logic [9:0] kp,
                         input int code, input int pulses, input int errs,
                         input int change, input int pulse_at);
    row_t r;
    r.raw = raw; r.cycles = cycles; r.kp = kp; r.code = code;
    r.pulses = pulses; r.errs = errs; r.change = change; r.pulse_at = pulse_at;
    rows.push_back(r);
  endtask

  task automatic run_table();
    logic [9:0] start_kp;
    int np, ne, first_change, first_pulse;
    logic bad;
    foreach (rows[r]) begin
      start_kp = keypad_a;
      np = 0; ne = 0; first_change = -1; first_pulse = -1;
      key_raw = rows[r].raw;
      for (int k = 0; k < rows[r].cycles; k++) begin
        tick();
        if (pulse_a) begin
          if (first_pulse < 0) first_pulse = k;
          np++;
        end
        if (err_a) ne++;
        if (first_change < 0 && keypad_a != start_kp) first_change = k;
        bad = (pulse_a && err_a) || (keypad_a != 10'b0 && !$onehot(keypad_a));
        check($sformatf("row%0d invariant", r), int'(bad), 0);
      end
      check($sformatf("row%0d keypad", r), int'(keypad_a), int'(rows[r].kp));
      check($sformatf("row%0d key_code", r), int'(code_a), rows[r].code);
      check($sformatf("row%0d pulses", r), np, rows[r].pulses);
      check($sformatf("row%0d errs", r), ne, rows[r].errs);
      check($sformatf("row%0d keypad change edge", r), first_change, rows[r].change);
      check($sformatf("row%0d pulse edge", r), first_pulse, rows[r].pulse_at);
    end
  endtask

  // ------------------------------------------------------- reference model
  // Tracks what the keypad means (held digit, lockout, run lengths) rather
  // than mimicking the design's state register.
  logic [9:0] m_s1, m_s2;
  bit         m_down, m_lock, m_pulse, m_err;
  int         m_cand, m_run, m_zeros, m_code;

  task automatic model_edge(input bit r, input logic [9:0] raw);
    logic [9:0] ks;
    int n, d;
    m_pulse = 1'b0;
    m_err   = 1'b0;
    if (r) begin
      m_s1 = '0; m_s2 = '0; m_down = 1'b0; m_lock = 1'b0;
      m_cand = -1; m_run = 0; m_zeros = 0; m_code = 0;
      return;
    end
    ks   = m_s2;
    m_s2 = m_s1;
    m_s1 = raw;
    n = $countones(ks);
    d = -1;
    for (int i = 0; i < 10; i++) if (ks[i]) d = i;
    if (m_lock) begin
      if (n == 0) m_zeros++; else m_zeros = 0;
      if (m_zeros >= RELC) begin m_lock = 1'b0; m_zeros = 0; end
    end else if (m_down) begin
      if (n == 0) begin
        m_zeros++;
        if (m_zeros >= RELC) begin m_down = 1'b0; m_cand = -1; m_zeros = 0; end
      end else if (n == 1 && d == m_cand) begin
        m_zeros = 0;
      end else begin
        m_down = 1'b0; m_cand = -1; m_lock = 1'b1; m_zeros = 0; m_err = 1'b1;
      end
    end else if (n > 1) begin
      m_lock = 1'b1; m_cand = -1; m_zeros = 0; m_err = 1'b1;
    end else if (n == 0) begin
      m_cand = -1;
    end else if (d == m_cand) begin
      m_run++;
      if (m_run >= DEB) begin
        m_down = 1'b1; m_code = d; m_pulse = 1'b1; m_zeros = 0;
      end
    end else begin
      m_cand = d;
      m_run  = 1;
    end
  endtask

  task automatic random_test();
    int kind, len, digit, other, cyc;
    logic [9:0] exp_kp;
    rst = 1'b1; key_raw = '0;
    tick(); model_edge(1'b1, key_raw);
    rst = 1'b0;
    cyc = 0;
    while (cyc < 4000) begin
      kind  = $urandom_range(0, 11);
      len   = $urandom_range(1, 45);
      digit = $urandom_range(0, 9);
      other = (digit + $urandom_range(1, 9)) % 10;
      for (int k = 0; k < len; k++) begin
        case (kind)
          0, 1, 2:       key_raw = '0;
          3, 4, 5, 6, 7: key_raw = 10'(1 << digit);
          8:             key_raw = 10'((1 << digit) | (1 << other));
          9, 10:         key_raw = ($urandom_range(0, 1) != 0) ? 10'(1 << digit) : 10'b0;
          default:       key_raw = (k < len / 2) ? 10'(1 << digit) : 10'(1 << other);
        endcase
        rst = ($urandom_range(0, 499) == 0);
        tick();
        model_edge(rst, key_raw);
        exp_kp = m_down ? 10'(1 << m_cand) : 10'b0;
        check($sformatf("rand c%0d keypad", cyc), int'(keypad_a), int'(exp_kp));
        check($sformatf("rand c%0d key_code", cyc), int'(code_a), m_code);
        check($sformatf("rand c%0d key_pulse", cyc), int'(pulse_a), int'(m_pulse));
        check($sformatf("rand c%0d key_err", cyc), int'(err_a), int'(m_err));
        cyc++;
      end
    end
    rst = 1'b0;
    key_raw = '0;
    repeat (30) tick();
  endtask

  // ------------------------------------------------------ hand sequences
  task automatic reset_mid_press();
    int n;
    bit got;
    key_raw = 10'h010;
    repeat (30) tick();
    check("midrst pressed keypad", int'(keypad_a), 'h010);
    rst = 1'b1;
    tick();
    check("midrst keypad", int'(keypad_a), 0);
    check("midrst key_code", int'(code_a), 0);
    check("midrst key_pulse", int'(pulse_a), 0);
    check("midrst key_err", int'(err_a), 0);
    rst = 1'b0;
    n = 0; got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      tick();
      n++;
      if (pulse_a) got = 1'b1;
    end
    check("midrst re-press latency", got ? n : -1, DEB + 2);
    check("midrst re-press code", int'(code_a), 4);
    key_raw = '0;
    repeat (30) tick();
    check("midrst released keypad", int'(keypad_a), 0);
  endtask

  task automatic auto_repeat();
    bit nz[170];
    int plist[$];
    int nerr, f, l, zeros, reassert;
    bit isolated;
    rst = 1'b1; key_raw = '0;
    tick(); tick();
    rst = 1'b0;
    nerr = 0;
    for (int k = 0; k < 170; k++) begin
      key_raw = (k < 130) ? 10'h001 : 10'h000;
      tick();
      nz[k] = (keypad_b != 10'b0);
      if (pulse_b) plist.push_back(k);
      if (err_b) nerr++;
    end
    check("rep pulse count", plist.size(), 5);
    check("rep first interval", (plist.size() >= 2) ? plist[1] - plist[0] : -1, 50);
    check("rep 2nd interval", (plist.size() >= 3) ? plist[2] - plist[1] : -1, 20);
    check("rep 3rd interval", (plist.size() >= 4) ? plist[3] - plist[2] : -1, 20);
    check("rep 4th interval", (plist.size() >= 5) ? plist[4] - plist[3] : -1, 20);
    f = -1; l = -1;
    for (int k = 0; k < 170; k++) begin
      if (nz[k]) begin
        if (f < 0) f = k;
        l = k;
      end
    end
    zeros = 0; isolated = 1'b1;
    for (int k = f + 1; k < l; k++) begin
      if (k > 0 && !nz[k]) begin
        zeros++;
        if (!nz[k - 1] || !nz[k + 1]) isolated = 1'b0;
      end
    end
    reassert = 0;
    for (int i = 1; i < plist.size(); i++) begin
      if (plist[i] > 0 && nz[plist[i]] && !nz[plist[i] - 1]) reassert++;
    end
    check("rep gap cycles", zeros, 4);
    check("rep gaps single-cycle", int'(isolated), 1);
    check("rep pulse on re-assert", reassert, 4);
    check("rep key_err count", nerr, 0);
    check("rep key_code", int'(code_b), 0);
    check("rep released keypad", int'(nz[169]), 0);
  endtask

  // ------------------------------------------------------------ main flow
  initial begin
    // Idle, then clean press of digit 3 and its release
    add_row(10'h000,   5, 10'h000, 0, 0, 0, -1, -1);
    add_row(10'h008, 100, 10'h008, 3, 1, 0, 21, 21);
    add_row(10'h000,  30, 10'h000, 3, 0, 0, 21, -1);
    // Digit 7 bouncing every 5 cycles is never accepted
    for (int i = 0; i < 12; i++)
      add_row((i % 2 == 0) ? 10'h080 : 10'h000, 5, 10'h000, 3, 0, 0, -1, -1);
    add_row(10'h000,  25, 10'h000, 3, 0, 0, -1, -1);
    // Debounce boundary: 19 stable samples rejected, 20 accepted
    add_row(10'h040,  19, 10'h000, 3, 0, 0, -1, -1);
    add_row(10'h000,  25, 10'h000, 3, 0, 0, -1, -1);
    add_row(10'h040,  20, 10'h000, 3, 0, 0, -1, -1);
    add_row(10'h000,  30, 10'h000, 6, 1, 0,  1,  1);
    // Release bounce on digit 5: one press, level held throughout
    add_row(10'h020,  40, 10'h020, 5, 1, 0, 21, 21);
    add_row(10'h000,   8, 10'h020, 5, 0, 0, -1, -1);
    add_row(10'h020,  30, 10'h020, 5, 0, 0, -1, -1);
    add_row(10'h000,  30, 10'h000, 5, 0, 0, 21, -1);
    // Chord on top of digit 1, lockout, exactly 20 zero samples, then digit 9
    add_row(10'h002,  30, 10'h002, 1, 1, 0, 21, 21);
    add_row(10'h006,  20, 10'h000, 1, 0, 1,  2, -1);
    add_row(10'h002,  15, 10'h000, 1, 0, 0, -1, -1);
    add_row(10'h006,  10, 10'h000, 1, 0, 0, -1, -1);
    add_row(10'h002,  15, 10'h000, 1, 0, 0, -1, -1);
    add_row(10'h000,  20, 10'h000, 1, 0, 0, -1, -1);
    add_row(10'h200,  30, 10'h200, 9, 1, 0, 21, 21);
    add_row(10'h000,  30, 10'h000, 9, 0, 0, 21, -1);

    rst = 1'b1; key_raw = '0;
    tick(); tick();
    check("reset keypad", int'(keypad_a), 0);
    check("reset key_code", int'(code_a), 0);
    check("reset key_pulse", int'(pulse_a), 0);
    check("reset key_err", int'(err_a), 0);
    check("reset keypad (repeat inst)", int'(keypad_b), 0);
    rst = 1'b0;

    run_table();
    reset_mid_press();
    auto_repeat();
    random_test();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: actual=timeout required=completion");
    $fatal(1, "simulation did not complete");
  end

endmodule
`default_nettype wire
